alu_rs: RTL and testbench

- Reservation station that schedules instructions onto the combinational ALU.
- Accepts renamed instructions from the dispatcher and holds them until both operands are available.
- Captures operands broadcast on the two CDB ports: the ALU result bus and the load/store result bus.
- Each cycle, selects one ready entry, drives it to the ALU through registered outputs, and frees that entry.
- Sits between the dispatcher/ROB and the ALU; it is flushed on ROB mispredict.

---
 rtl/alu_rs_pkg.sv | 38 +++
 rtl/alu_rs_prio_enc.sv | 20 ++
 rtl/alu_rs.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode encodings, ROB tag width,
// default station depth and a one-hot to index helper.
package alu_rs_pkg;

    localparam int unsigned RobW          = 4;
    localparam int unsigned RsSizeDefault = 16;
    localparam int unsigned OhMaxW        = 64;

    // Internal opcodes, same encoding the ALU decodes.
    typedef enum logic [5:0] {
        OpAdd  = 6'd1,
        OpSub  = 6'd2,
        OpAnd  = 6'd3,
        OpOr   = 6'd4,
        OpXor  = 6'd5,
        OpSll  = 6'd6,
        OpSrl  = 6'd7,
        OpSra  = 6'd8,
        OpSlt  = 6'd9,
        OpAddi = 6'd10,
        OpAndi = 6'd11,
        OpOri  = 6'd12,
        OpXori = 6'd13,
        OpLui  = 6'd14,
        OpBeq  = 6'd15,
        OpBne  = 6'd16
    } alu_op_e;

    function automatic logic [5:0] onehot_to_idx(input logic [OhMaxW-1:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < OhMaxW; i++) begin
            if (oh[i]) idx = idx | 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Find-first-set: reports whether any request bit is set and the index of the lowest one.
module alu_rs_prio_enc
    import alu_rs_pkg::*;
#(
    parameter int unsigned N    = RsSizeDefault,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    logic [N-1:0] lowest;

    // Two's-complement trick isolates the lowest set bit.
    assign lowest  = req_i & (~req_i + N'(1));
    assign valid_o = |req_i;
    assign idx_o   = IdxW'(onehot_to_idx(OhMaxW'(lowest)));

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed instructions until both operands arrive on the
// CDBs, then dispatches the lowest-index ready entry to the ALU through registered outputs.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE = RsSizeDefault,
    parameter int unsigned ROB_W   = RobW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rdy_i,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic [5:0]       issue_opcode_i,
    input  logic [31:0]      issue_vj_i,
    input  logic [31:0]      issue_vk_i,
    input  logic [ROB_W-1:0] issue_qj_i,
    input  logic [ROB_W-1:0] issue_qk_i,
    input  logic             issue_qj_pend_i,
    input  logic             issue_qk_pend_i,
    input  logic [31:0]      issue_imm_i,
    input  logic [31:0]      issue_pc_i,
    input  logic [ROB_W-1:0] issue_rob_i,
    output logic             full_o,
    input  logic             alu_cdb_valid_i,
    input  logic [ROB_W-1:0] alu_cdb_rob_i,
    input  logic [31:0]      alu_cdb_val_i,
    input  logic             lsb_cdb_valid_i,
    input  logic [ROB_W-1:0] lsb_cdb_rob_i,
    input  logic [31:0]      lsb_cdb_val_i,
    output logic             alu_sgn_o,
    output logic [5:0]       alu_opcode_o,
    output logic [31:0]      alu_lhs_o,
    output logic [31:0]      alu_rhs_o,
    output logic [31:0]      alu_imm_o,
    output logic [31:0]      alu_pc_o,
    output logic [ROB_W-1:0] alu_rob_o
);

    localparam int unsigned IdxW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d, pj_q, pj_d, pk_q, pk_d;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_d  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];

    logic             sgn_q, sgn_d;
    logic [5:0]       out_op_q, out_op_d;
    logic [31:0]      lhs_q, lhs_d, rhs_q, rhs_d, out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [ROB_W-1:0] out_rob_q, out_rob_d;

    logic [RS_SIZE-1:0] ready, free;
    logic               free_vld, sel_vld;
    logic [IdxW-1:0]    free_idx, sel_idx;
    logic [31:0]        iss_vj, iss_vk;
    logic               iss_pj, iss_pk;

    // Selection looks only at state from the start of the cycle, so a fresh issue waits a cycle.
    assign ready  = busy_q & ~pj_q & ~pk_q;
    assign free   = ~busy_q;
    assign full_o = &busy_q;

    alu_rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
        .req_i   (free),
        .valid_o (free_vld),
        .idx_o   (free_idx)
    );

    alu_rs_prio_enc #(.N(RS_SIZE)) u_sel_enc (
        .req_i   (ready),
        .valid_o (sel_vld),
        .idx_o   (sel_idx)
    );

    // Same-cycle forwarding for the incoming instruction; the ALU bus wins a tag tie.
    always_comb begin
        iss_vj = issue_vj_i;
        iss_pj = issue_qj_pend_i;
        iss_vk = issue_vk_i;
        iss_pk = issue_qk_pend_i;
        if (issue_qj_pend_i) begin
            if (alu_cdb_valid_i && alu_cdb_rob_i == issue_qj_i) begin
                iss_vj = alu_cdb_val_i;
                iss_pj = 1'b0;
            end else if (lsb_cdb_valid_i && lsb_cdb_rob_i == issue_qj_i) begin
                iss_vj = lsb_cdb_val_i;
                iss_pj = 1'b0;
            end
        end
        if (issue_qk_pend_i) begin
            if (alu_cdb_valid_i && alu_cdb_rob_i == issue_qk_i) begin
                iss_vk = alu_cdb_val_i;
                iss_pk = 1'b0;
            end else if (lsb_cdb_valid_i && lsb_cdb_rob_i == issue_qk_i) begin
                iss_vk = lsb_cdb_val_i;
                iss_pk = 1'b0;
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        pj_d      = pj_q;
        pk_d      = pk_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        rob_d     = rob_q;
        sgn_d     = 1'b0;
        out_op_d  = out_op_q;
        lhs_d     = lhs_q;
        rhs_d     = rhs_q;
        out_imm_d = out_imm_q;
        out_pc_d  = out_pc_q;
        out_rob_d = out_rob_q;

        if (rdy_i) begin
            if (flush_i) begin
                busy_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && pj_q[i]) begin
                        if (alu_cdb_valid_i && alu_cdb_rob_i == qj_q[i]) begin
                            vj_d[i] = alu_cdb_val_i;
                            pj_d[i] = 1'b0;
                        end else if (lsb_cdb_valid_i && lsb_cdb_rob_i == qj_q[i]) begin
                            vj_d[i] = lsb_cdb_val_i;
                            pj_d[i] = 1'b0;
                        end
                    end
                    if (busy_q[i] && pk_q[i]) begin
                        if (alu_cdb_valid_i && alu_cdb_rob_i == qk_q[i]) begin
                            vk_d[i] = alu_cdb_val_i;
                            pk_d[i] = 1'b0;
                        end else if (lsb_cdb_valid_i && lsb_cdb_rob_i == qk_q[i]) begin
                            vk_d[i] = lsb_cdb_val_i;
                            pk_d[i] = 1'b0;
                        end
                    end
                end

                if (sel_vld) begin
                    busy_d[sel_idx] = 1'b0;
                    sgn_d           = 1'b1;
                    out_op_d        = op_q[sel_idx];
                    lhs_d           = vj_q[sel_idx];
                    rhs_d           = vk_q[sel_idx];
                    out_imm_d       = imm_q[sel_idx];
                    out_pc_d        = pc_q[sel_idx];
                    out_rob_d       = rob_q[sel_idx];
                end

                // The free slot is never the selected one, so both writes can coexist.
                if (issue_valid_i && free_vld) begin
                    busy_d[free_idx] = 1'b1;
                    op_d[free_idx]   = issue_opcode_i;
                    vj_d[free_idx]   = iss_vj;
                    vk_d[free_idx]   = iss_vk;
                    pj_d[free_idx]   = iss_pj;
                    pk_d[free_idx]   = iss_pk;
                    qj_d[free_idx]   = issue_qj_i;
                    qk_d[free_idx]   = issue_qk_i;
                    imm_d[free_idx]  = issue_imm_i;
                    pc_d[free_idx]   = issue_pc_i;
                    rob_d[free_idx]  = issue_rob_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            pj_q      <= '0;
            pk_q      <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            sgn_q     <= 1'b0;
            out_op_q  <= '0;
            lhs_q     <= '0;
            rhs_q     <= '0;
            out_imm_q <= '0;
            out_pc_q  <= '0;
            out_rob_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pj_q      <= pj_d;
            pk_q      <= pk_d;
            op_q      <= op_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            rob_q     <= rob_d;
            sgn_q     <= sgn_d;
            out_op_q  <= out_op_d;
            lhs_q     <= lhs_d;
            rhs_q     <= rhs_d;
            out_imm_q <= out_imm_d;
            out_pc_q  <= out_pc_d;
            out_rob_q <= out_rob_d;
        end
    end

    assign alu_sgn_o    = sgn_q;
    assign alu_opcode_o = out_op_q;
    assign alu_lhs_o    = lhs_q;
    assign alu_rhs_o    = rhs_q;
    assign alu_imm_o    = out_imm_q;
    assign alu_pc_o     = out_pc_q;
    assign alu_rob_o    = out_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: table-driven vectors, directed corner sequences and a
// randomized run compared every cycle against a slot-level reference model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst_n, rdy, flush;
    logic          issue_valid, issue_qj_pend, issue_qk_pend;
    logic [5:0]    issue_opcode;
    logic [31:0]   issue_vj, issue_vk, issue_imm, issue_pc;
    logic [RW-1:0] issue_qj, issue_qk, issue_rob;
    logic          full;
    logic          alu_cdb_valid, lsb_cdb_valid;
    logic [RW-1:0] alu_cdb_rob, lsb_cdb_rob;
    logic [31:0]   alu_cdb_val, lsb_cdb_val;
    logic          alu_sgn;
    logic [5:0]    alu_opcode;
    logic [31:0]   alu_lhs, alu_rhs, alu_imm, alu_pc;
    logic [RW-1:0] alu_rob;

    always #5 clk = ~clk;

    alu_rs #(.RS_SIZE(N), .ROB_W(RW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rdy_i           (rdy),
        .flush_i         (flush),
        .issue_valid_i   (issue_valid),
        .issue_opcode_i  (issue_opcode),
        .issue_vj_i      (issue_vj),
        .issue_vk_i      (issue_vk),
        .issue_qj_i      (issue_qj),
        .issue_qk_i      (issue_qk),
        .issue_qj_pend_i (issue_qj_pend),
        .issue_qk_pend_i (issue_qk_pend),
        .issue_imm_i     (issue_imm),
        .issue_pc_i      (issue_pc),
        .issue_rob_i     (issue_rob),
        .full_o          (full),
        .alu_cdb_valid_i (alu_cdb_valid),
        .alu_cdb_rob_i   (alu_cdb_rob),
        .alu_cdb_val_i   (alu_cdb_val),
        .lsb_cdb_valid_i (lsb_cdb_valid),
        .lsb_cdb_rob_i   (lsb_cdb_rob),
        .lsb_cdb_val_i   (lsb_cdb_val),
        .alu_sgn_o       (alu_sgn),
        .alu_opcode_o    (alu_opcode),
        .alu_lhs_o       (alu_lhs),
        .alu_rhs_o       (alu_rhs),
        .alu_imm_o       (alu_imm),
        .alu_pc_o        (alu_pc),
        .alu_rob_o       (alu_rob)
    );

    typedef struct {
        bit          busy;
        bit          pj;
        bit          pk;
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  qj, qk, rob;
    } ment_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        logic [3:0]  rob;
        logic [31:0] exp_lhs, exp_rhs;
        logic [3:0]  exp_rob;
    } vec_t;

    ment_t       m [N];
    logic        m_sgn;
    logic [5:0]  m_op;
    logic [31:0] m_lhs, m_rhs, m_imm, m_pc;
    logic [3:0]  m_rob;
    vec_t        vecs [4];

    int n_checks = 0;
    int n_errors = 0;
    bit allow_full_issue = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '{default: '0};
        m_sgn = 1'b0; m_op = '0; m_lhs = '0; m_rhs = '0; m_imm = '0; m_pc = '0; m_rob = '0;
    endtask

    // Value broadcast this cycle for a tag, ALU bus first.
    task automatic cdb_find(input logic [3:0] tag, output bit hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        if (alu_cdb_valid && alu_cdb_rob == tag) begin
            hit = 1'b1; val = alu_cdb_val;
        end else if (lsb_cdb_valid && lsb_cdb_rob == tag) begin
            hit = 1'b1; val = lsb_cdb_val;
        end
    endtask

    task automatic model_edge();
        ment_t       nx [N];
        int          sel, slot;
        bit          hit;
        logic [31:0] val;
        nx   = m;
        sel  = -1;
        slot = -1;
        if (!rdy) begin
            m_sgn = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) nx[i].busy = 1'b0;
            m_sgn = 1'b0;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (m[i].busy && !m[i].pj && !m[i].pk) sel = i;
                if (!m[i].busy) slot = i;
            end
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && m[i].pj) begin
                    cdb_find(m[i].qj, hit, val);
                    if (hit) begin nx[i].vj = val; nx[i].pj = 1'b0; end
                end
                if (m[i].busy && m[i].pk) begin
                    cdb_find(m[i].qk, hit, val);
                    if (hit) begin nx[i].vk = val; nx[i].pk = 1'b0; end
                end
            end
            if (sel >= 0) begin
                m_sgn = 1'b1; m_op = m[sel].op; m_lhs = m[sel].vj; m_rhs = m[sel].vk;
                m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
                nx[sel].busy = 1'b0;
            end else begin
                m_sgn = 1'b0;
            end
            if (issue_valid && slot >= 0) begin
                nx[slot] = '{busy: 1'b1, pj: issue_qj_pend, pk: issue_qk_pend, op: issue_opcode,
                             vj: issue_vj, vk: issue_vk, imm: issue_imm, pc: issue_pc,
                             qj: issue_qj, qk: issue_qk, rob: issue_rob};
                if (issue_qj_pend) begin
                    cdb_find(issue_qj, hit, val);
                    if (hit) begin nx[slot].vj = val; nx[slot].pj = 1'b0; end
                end
                if (issue_qk_pend) begin
                    cdb_find(issue_qk, hit, val);
                    if (hit) begin nx[slot].vk = val; nx[slot].pk = 1'b0; end
                end
            end
        end
        m = nx;
    endtask

    // One clock: protocol checks, model update, then compare every output 1 time unit later.
    task automatic step();
        if (rdy && alu_cdb_valid && lsb_cdb_valid && alu_cdb_rob == lsb_cdb_rob) begin
            n_errors++;
            $display("FAIL protocol_cdb_tag_clash: tag %h on both buses", alu_cdb_rob);
        end
        if (rdy && !flush && issue_valid && m_full() && !allow_full_issue) begin
            n_errors++;
            $display("FAIL protocol_issue_full: issue_valid %b while full %b", issue_valid, 1'b1);
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("sgn", 32'(alu_sgn), 32'(m_sgn));
        chk("opcode", 32'(alu_opcode), 32'(m_op));
        chk("lhs", alu_lhs, m_lhs);
        chk("rhs", alu_rhs, m_rhs);
        chk("imm", alu_imm, m_imm);
        chk("pc", alu_pc, m_pc);
        chk("rob", 32'(alu_rob), 32'(m_rob));
        chk("full", 32'(full), 32'(m_full()));
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0;
        issue_qj_pend = 1'b0; issue_qk_pend = 1'b0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [3:0] qj, input bit pj, input logic [3:0] qk,
                             input bit pk, input logic [3:0] rob);
        issue_valid = 1'b1; issue_opcode = op; issue_vj = vj; issue_vk = vk;
        issue_qj = qj; issue_qj_pend = pj; issue_qk = qk; issue_qk_pend = pk;
        issue_rob = rob; issue_imm = 32'h1000 + 32'(rob); issue_pc = 32'h8000_0000 + 32'(rob) * 4;
    endtask

    initial begin
        vecs[0] = '{op: OpAdd,  vj: 32'd5,         vk: 32'd7,         imm: 32'd0,
                    pc: 32'h100, rob: 4'd3, exp_lhs: 32'd5, exp_rhs: 32'd7, exp_rob: 4'd3};
        vecs[1] = '{op: OpSub,  vj: 32'hFFFF_FFFF, vk: 32'h1,         imm: 32'd0,
                    pc: 32'h104, rob: 4'd15, exp_lhs: 32'hFFFF_FFFF, exp_rhs: 32'h1,
                    exp_rob: 4'd15};
        vecs[2] = '{op: OpAddi, vj: 32'h1234_5678, vk: 32'd0,         imm: 32'hFFFF_FFF0,
                    pc: 32'h108, rob: 4'd0, exp_lhs: 32'h1234_5678, exp_rhs: 32'd0,
                    exp_rob: 4'd0};
        vecs[3] = '{op: OpXor,  vj: 32'hA5A5_A5A5, vk: 32'h5A5A_5A5A, imm: 32'd0,
                    pc: 32'h10C, rob: 4'd9, exp_lhs: 32'hA5A5_A5A5, exp_rhs: 32'h5A5A_5A5A,
                    exp_rob: 4'd9};

        issue_opcode = '0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
        issue_imm = '0; issue_pc = '0; issue_rob = '0;
        alu_cdb_rob = '0; alu_cdb_val = '0; lsb_cdb_rob = '0; lsb_cdb_val = '0;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sgn", 32'(alu_sgn), 32'd0);
        chk("reset_lhs", alu_lhs, 32'd0);
        chk("reset_rob", 32'(alu_rob), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        rst_n = 1'b1;

        // Ready instructions from the table: dispatched one edge after issue, then idle.
        for (int v = 0; v < 4; v++) begin
            set_issue(vecs[v].op, vecs[v].vj, vecs[v].vk, 4'd0, 1'b0, 4'd0, 1'b0, vecs[v].rob);
            issue_imm = vecs[v].imm; issue_pc = vecs[v].pc;
            step();
            chk("vec_sgn_before", 32'(alu_sgn), 32'd0);
            idle_inputs();
            step();
            chk("vec_sgn", 32'(alu_sgn), 32'd1);
            chk("vec_lhs", alu_lhs, vecs[v].exp_lhs);
            chk("vec_rhs", alu_rhs, vecs[v].exp_rhs);
            chk("vec_rob", 32'(alu_rob), 32'(vecs[v].exp_rob));
            chk("vec_op", 32'(alu_opcode), 32'(vecs[v].op));
            chk("vec_pc", alu_pc, vecs[v].pc);
            step();
            chk("vec_sgn_after", 32'(alu_sgn), 32'd0);
            chk("vec_lhs_hold", alu_lhs, vecs[v].exp_lhs);
        end

        // Operand woken by the load/store bus.
        set_issue(OpAddi, 32'd0, 32'd0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd6);
        step();
        idle_inputs();
        step();
        chk("wake_wait", 32'(alu_sgn), 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd9; lsb_cdb_val = 32'h100;
        step();
        chk("wake_capture_edge", 32'(alu_sgn), 32'd0);
        idle_inputs();
        step();
        chk("wake_sgn", 32'(alu_sgn), 32'd1);
        chk("wake_lhs", alu_lhs, 32'h100);

        // Same-cycle forwarding from the ALU bus.
        set_issue(OpAdd, 32'd2, 32'd0, 4'd0, 1'b0, 4'd4, 1'b1, 4'd7);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_val = 32'hABCD;
        step();
        idle_inputs();
        step();
        chk("fwd_sgn", 32'(alu_sgn), 32'd1);
        chk("fwd_rhs", alu_rhs, 32'hABCD);

        // Fill every slot with waiting instructions; slot 5 waits on a unique tag.
        for (int i = 0; i < N; i++) begin
            set_issue(OpOr, 32'd0, 32'(i), (i == 5) ? 4'd2 : 4'd1, 1'b1, 4'd0, 1'b0, 4'(i));
            step();
        end
        chk("fill_full", 32'(full), 32'd1);
        allow_full_issue = 1'b1;
        set_issue(OpOr, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14);
        step();
        allow_full_issue = 1'b0;
        chk("fill_ignored_sgn", 32'(alu_sgn), 32'd0);
        chk("fill_still_full", 32'(full), 32'd1);
        idle_inputs();
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_val = 32'h55;
        step();
        idle_inputs();
        step();
        chk("fill_disp_sgn", 32'(alu_sgn), 32'd1);
        chk("fill_disp_rob", 32'(alu_rob), 32'd5);
        chk("fill_disp_lhs", alu_lhs, 32'h55);
        chk("fill_not_full", 32'(full), 32'd0);
        flush = 1'b1;
        step();
        idle_inputs();

        // Two entries become ready together: lower index goes first.
        for (int i = 0; i < 8; i++) begin
            set_issue(OpAnd, 32'd0, 32'd0, (i == 2 || i == 7) ? 4'd3 : 4'd1, 1'b1, 4'd0, 1'b0,
                      4'(i));
            step();
        end
        idle_inputs();
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd3; alu_cdb_val = 32'h77;
        step();
        idle_inputs();
        step();
        chk("prio_first", 32'(alu_rob), 32'd2);
        step();
        chk("prio_second_sgn", 32'(alu_sgn), 32'd1);
        chk("prio_second", 32'(alu_rob), 32'd7);
        step();
        chk("prio_done", 32'(alu_sgn), 32'd0);
        flush = 1'b1;
        step();
        idle_inputs();

        // Flush with busy entries beats a same-cycle issue.
        for (int i = 0; i < 6; i++) begin
            set_issue(OpSll, 32'd0, 32'd0, 4'd1, 1'b1, 4'd0, 1'b0, 4'(i));
            step();
        end
        set_issue(OpAdd, 32'd9, 32'd9, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12);
        flush = 1'b1;
        step();
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_sgn", 32'(alu_sgn), 32'd0);
        idle_inputs();
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd1; alu_cdb_val = 32'h1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("flush_no_dispatch", 32'(alu_sgn), 32'd0);
        end
        idle_inputs();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 99) == 0);
            issue_valid   = ($urandom_range(0, 1) == 1) && !m_full();
            issue_opcode  = 6'($urandom_range(1, 16));
            issue_vj      = $urandom;
            issue_vk      = $urandom;
            issue_imm     = $urandom;
            issue_pc      = $urandom;
            issue_qj      = 4'($urandom);
            issue_qk      = 4'($urandom);
            issue_qj_pend = ($urandom_range(0, 2) == 0);
            issue_qk_pend = ($urandom_range(0, 2) == 0);
            issue_rob     = 4'($urandom);
            alu_cdb_valid = ($urandom_range(0, 1) == 1);
            alu_cdb_rob   = 4'($urandom);
            alu_cdb_val   = $urandom;
            lsb_cdb_valid = ($urandom_range(0, 1) == 1);
            lsb_cdb_rob   = 4'($urandom);
            lsb_cdb_val   = $urandom;
            if (lsb_cdb_rob == alu_cdb_rob) lsb_cdb_rob = lsb_cdb_rob ^ 4'd1;
            step();
        end

        // Asynchronous reset mid-stream: outputs clear without waiting for an edge.
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            set_issue(OpAdd, 32'hDEAD_0000 + 32'(i), 32'hBEEF, 4'd0, 1'b0, 4'd0, 1'b0, 4'(i + 1));
            step();
        end
        idle_inputs();
        step();
        chk("pre_reset_sgn", 32'(alu_sgn), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_sgn", 32'(alu_sgn), 32'd0);
        chk("async_lhs", alu_lhs, 32'd0);
        chk("async_rhs", alu_rhs, 32'd0);
        chk("async_rob", 32'(alu_rob), 32'd0);
        chk("async_full", 32'(full), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("post_reset_idle", 32'(alu_sgn), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
